matmul_result_checker: RTL

- Hardware self-checker for the RISC-V CPU's matrix-multiply program; the successor to the bench-side result comparison, parametrised in matrix shape and data width.
- After the CPU raises done, it reads matrix1, matrix2 and the CPU-written result matrix from data memory through a word read port.
- It recomputes every product element and reports pass/fail, the mismatch count and the first mismatch location.
- Sits beside D_Memory on the FPGA top level; also drives on-board LEDs.

---
 rtl/matchk_pkg.sv | 34 +++
 rtl/matchk_mac.sv | 31 +++
 rtl/matmul_result_checker.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/matchk_pkg.sv
// Shared types and constants for the matrix-multiply result checker.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
package matchk_pkg;

  // Width of the saturating mismatch counter
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    MAC  = 3'd3,
    RD_C = 3'd4,
    CMP  = 3'd5,
    DONE = 3'd6
  } state_t;

  // Byte base of matrix1 (M x N)
  function automatic int a_base();
    return 0;
  endfunction

  // Byte base of matrix2 (N x N2), directly after matrix1
  function automatic int b_base(input int m, input int n);
    return m * n * 4;
  endfunction

  // Byte base of the CPU-written result (M x N2), directly after matrix2
  function automatic int c_base(input int m, input int n, input int n2);
    return m * n * 4 + n * n2 * 4;
  endfunction

endpackage

// File: rtl/matchk_mac.sv
// Registered DW-bit multiply-accumulate; product and sum wrap at DW bits.
// Latency: acc updates on the clock edge after en/clr is sampled.
// Backpressure: none; clr has priority over en.
module matchk_mac #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] acc
);

  // Low DW bits of the product are identical for signed and unsigned operands
  logic [DW-1:0] prod;
  assign prod = a * b;

  // Accumulator: clear wins over accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod;
    end
  end

endmodule

// File: rtl/matmul_result_checker.sv
// Recomputes C = A*B from data memory and compares against the CPU result.
// Latency: done rises M*N2*(3N+2)+1 cycles after the start cycle.
// Backpressure: none; memory must return rd_data one cycle after rd_en. Optional: MATCHK_CYCLE_CNT_EN.
module matmul_result_checker
  import matchk_pkg::*;
#(
  parameter int M  = 3,
  parameter int N  = 4,
  parameter int N2 = 1,
  parameter int DW = 32,
  parameter int AW = 16
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             start,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [DW-1:0]    rd_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [7:0]       first_row,
  output logic [7:0]       first_col,
  output logic [DW-1:0]    first_expected
`ifdef MATCHK_CYCLE_CNT_EN
  ,
  output logic [31:0]      check_cycles
`endif
);

  localparam int IW_M  = (M  > 1) ? $clog2(M)  : 1;
  localparam int IW_N  = (N  > 1) ? $clog2(N)  : 1;
  localparam int IW_N2 = (N2 > 1) ? $clog2(N2) : 1;

  state_t           state;
  logic [IW_M-1:0]  i;
  logic [IW_N2-1:0] j;
  logic [IW_N-1:0]  k;
  logic [DW-1:0]    a_q;
  logic [DW-1:0]    acc;

  logic accept;
  logic mac_clr;
  logic mac_en;
  logic mism;
  logic last_i;
  logic last_j;
  logic last_k;
  logic cnt_sat;

  function automatic logic [AW-1:0] addr_a(input int ii, input int kk);
    return AW'(a_base() + (ii * N + kk) * 4);
  endfunction

  function automatic logic [AW-1:0] addr_b(input int kk, input int jj);
    return AW'(b_base(M, N) + (kk * N2 + jj) * 4);
  endfunction

  function automatic logic [AW-1:0] addr_c(input int ii, input int jj);
    return AW'(c_base(M, N, N2) + (ii * N2 + jj) * 4);
  endfunction

  assign accept  = start && ((state == IDLE) || (state == DONE));
  assign mac_clr = accept || (state == CMP);
  assign mac_en  = (state == MAC);
  assign mism    = (rd_data != acc);
  assign last_i  = (i == IW_M'(M - 1));
  assign last_j  = (j == IW_N2'(N2 - 1));
  assign last_k  = (k == IW_N'(N - 1));
  assign cnt_sat = &mismatch_count;

  matchk_mac #(.DW(DW)) u_mac (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (a_q),
    .b     (rd_data),
    .acc   (acc)
  );

  // Sequencer: outputs are registered on entry to each state, so rd_en/rd_addr
  // are valid during the read states and rd_data arrives in the following state
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state          <= IDLE;
      i              <= '0;
      j              <= '0;
      k              <= '0;
      a_q            <= '0;
      rd_en          <= 1'b0;
      rd_addr        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_count <= '0;
      first_row      <= '0;
      first_col      <= '0;
      first_expected <= '0;
    end else begin
      rd_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= RD_A;
            i              <= '0;
            j              <= '0;
            k              <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_count <= '0;
            first_row      <= '0;
            first_col      <= '0;
            first_expected <= '0;
            rd_en          <= 1'b1;
            rd_addr        <= addr_a(0, 0);
          end
        end
        RD_A: begin
          state   <= RD_B;
          rd_en   <= 1'b1;
          rd_addr <= addr_b(int'(k), int'(j));
        end
        RD_B: begin
          a_q   <= rd_data;
          state <= MAC;
        end
        MAC: begin
          rd_en <= 1'b1;
          if (last_k) begin
            k       <= '0;
            state   <= RD_C;
            rd_addr <= addr_c(int'(i), int'(j));
          end else begin
            k       <= k + 1'b1;
            state   <= RD_A;
            rd_addr <= addr_a(int'(i), int'(k) + 1);
          end
        end
        RD_C: begin
          state <= CMP;
        end
        CMP: begin
          if (mism) begin
            if (!cnt_sat) begin
              mismatch_count <= mismatch_count + 1'b1;
            end
            if (mismatch_count == '0) begin
              first_row      <= 8'(i);
              first_col      <= 8'(j);
              first_expected <= acc;
            end
          end
          if (last_i && last_j) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (mismatch_count == '0) && !mism;
          end else begin
            state <= RD_A;
            rd_en <= 1'b1;
            if (last_j) begin
              j       <= '0;
              i       <= i + 1'b1;
              rd_addr <= addr_a(int'(i) + 1, 0);
            end else begin
              j       <= j + 1'b1;
              rd_addr <= addr_a(int'(i), 0);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MATCHK_CYCLE_CNT_EN
  // Cycle counter: the start cycle counts as 1 so the final value equals the
  // start-to-done latency; it then advances on every busy cycle and freezes in DONE
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      check_cycles <= '0;
    end else if (accept) begin
      check_cycles <= 32'd1;
    end else if (busy) begin
      check_cycles <= check_cycles + 32'd1;
    end
  end
`endif

endmodule
